// File: rtl/alu_exec_if.sv
// alu_exec_if: operand/opcode/start bundle from the register-file memory
// plus the registered result and status flags returned by the execution stage.
interface alu_exec_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]   A;
    logic [DATA_WIDTH-1:0]   B;
    logic [2:0]              oper;
    logic                    exec;
    logic [2*DATA_WIDTH-1:0] result;
    logic                    busy;
    logic                    done;
    logic                    carry;
    logic                    zero;
    logic                    err;

    modport master (
        output A, B, oper, exec,
        input  result, busy, done, carry, zero, err
    );

    modport slave (
        input  A, B, oper, exec,
        output result, busy, done, carry, zero, err
    );
endinterface

// File: rtl/alu_exec.sv
// alu_exec: execution stage behind the register-file memory. Single-cycle
// logic/arithmetic ops plus iterative shift-add multiply and restoring divide.
module alu_exec #(
    parameter int DATA_WIDTH = 8
) (
    input logic       clk,
    input logic       reset,
    alu_exec_if.slave bus
);
    localparam int W   = DATA_WIDTH;
    localparam int SHW = $clog2(W);
    localparam int CW  = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_MUL = 3'd6;
    localparam logic [2:0] OP_DIV = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t          state;
    state_t          state_next;
    logic            exec_d;
    logic            start;
    logic            complete;
    logic [CW-1:0]   count;
    logic [W-1:0]    work_a;
    logic [2*W-1:0]  work_b;
    logic [2*W-1:0]  acc;
    logic [W:0]      sum;
    logic [W:0]      diff;
    logic [W:0]      div_shift;
    logic [W:0]      div_trial;
    logic [W-1:0]    div_rem_next;
    logic [W-1:0]    div_quo_next;
    logic [2*W-1:0]  mul_acc_sum;
    logic [2*W-1:0]  shl_full;
    logic [2*W-1:0]  result_next;
    logic            carry_next;
    logic            err_next;

    // exec_d resets high so the memory's all-ones reset value is not an edge
    assign start = bus.exec && !exec_d && (state == S_IDLE);

    assign sum      = {1'b0, bus.A} + {1'b0, bus.B};
    assign diff     = {1'b0, bus.A} - {1'b0, bus.B};
    assign shl_full = {{W{1'b0}}, bus.A} << bus.B[SHW-1:0];

    // MUL: work_a holds the multiplier (LSB first), work_b the shifting multiplicand
    assign mul_acc_sum = acc + (work_a[0] ? work_b : '0);

    // DIV: acc holds the partial remainder, work_a shifts dividend out and quotient in
    assign div_shift    = {acc[W-1:0], work_a[W-1]};
    assign div_trial    = div_shift - {1'b0, work_b[W-1:0]};
    assign div_rem_next = div_trial[W] ? div_shift[W-1:0] : div_trial[W-1:0];
    assign div_quo_next = {work_a[W-2:0], ~div_trial[W]};

    assign bus.busy = (state != S_IDLE);

    always_comb begin
        state_next  = state;
        complete    = 1'b0;
        result_next = '0;
        carry_next  = 1'b0;
        err_next    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    complete = 1'b1;
                    case (bus.oper)
                        OP_ADD: begin
                            result_next = {{(W-1){1'b0}}, sum};
                            carry_next  = sum[W];
                        end
                        OP_SUB: begin
                            result_next = {{W{1'b0}}, diff[W-1:0]};
                            carry_next  = diff[W];
                        end
                        OP_AND: result_next = {{W{1'b0}}, bus.A & bus.B};
                        OP_OR:  result_next = {{W{1'b0}}, bus.A | bus.B};
                        OP_XOR: result_next = {{W{1'b0}}, bus.A ^ bus.B};
                        OP_SHL: result_next = shl_full;
                        OP_MUL: begin
                            complete   = 1'b0;
                            state_next = S_MUL;
                        end
                        default: begin
                            if (bus.B == '0) begin
                                result_next = '1;
                                err_next    = 1'b1;
                            end else begin
                                complete   = 1'b0;
                                state_next = S_DIV;
                            end
                        end
                    endcase
                end
            end
            S_MUL: begin
                if (count == LAST) begin
                    complete    = 1'b1;
                    result_next = mul_acc_sum;
                    state_next  = S_IDLE;
                end
            end
            S_DIV: begin
                if (count == LAST) begin
                    complete    = 1'b1;
                    result_next = {div_rem_next, div_quo_next};
                    state_next  = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            exec_d <= 1'b1;
        end else begin
            state  <= state_next;
            exec_d <= bus.exec;
        end
    end

    // Operand latch at the start edge, then one iteration per cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            work_a <= '0;
            work_b <= '0;
            acc    <= '0;
        end else if (start) begin
            count  <= '0;
            acc    <= '0;
            work_a <= (bus.oper == OP_MUL) ? bus.B : bus.A;
            work_b <= (bus.oper == OP_MUL) ? {{W{1'b0}}, bus.A} : {{W{1'b0}}, bus.B};
        end else if (state == S_MUL) begin
            count  <= count + 1'b1;
            acc    <= mul_acc_sum;
            work_a <= work_a >> 1;
            work_b <= work_b << 1;
        end else if (state == S_DIV) begin
            count  <= count + 1'b1;
            acc    <= {{W{1'b0}}, div_rem_next};
            work_a <= div_quo_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.result <= '0;
            bus.done   <= 1'b0;
            bus.carry  <= 1'b0;
            bus.zero   <= 1'b0;
            bus.err    <= 1'b0;
        end else begin
            bus.done <= complete;
            if (complete) begin
                bus.result <= result_next;
                bus.carry  <= carry_next;
                bus.zero   <= (result_next == '0);
                bus.err    <= err_next;
            end
        end
    end
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: randomized and directed stimulus for alu_exec; expected results
// come from an arithmetic model and are checked by a decoupled done-monitor.
module tb_alu_exec;
    localparam int W = 8;

    typedef struct {
        logic [2*W-1:0] result;
        logic           carry;
        logic           zero;
        logic           err;
        int             due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   compared;
    int   mismatched;
    int   done_count;
    exp_t sb_q[$];

    alu_exec_if #(.DATA_WIDTH(W)) bus();

    alu_exec #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op);
        exp_t        e;
        int unsigned ua;
        int unsigned ub;
        int unsigned r;
        ua      = a;
        ub      = b;
        e.carry = 1'b0;
        e.err   = 1'b0;
        e.due   = 0;
        case (op)
            3'd0: begin r = ua + ub; e.carry = (r > 255); end
            3'd1: begin r = (ua + 256 - ub) % 256; e.carry = (ua < ub); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = ua << (ub % 8);
            3'd6: r = ua * ub;
            default: begin
                if (ub == 0) begin
                    r     = 32'hFFFF;
                    e.err = 1'b1;
                end else begin
                    r = (ua % ub) * 256 + ua / ub;
                end
            end
        endcase
        e.result = r[15:0];
        e.zero   = (e.result == 0);
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic apply_stimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [2:0] op);
        exp_t e;
        int   guard;
        guard = 0;
        while (bus.busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check_output("busy_timeout", 32'd1, 32'd0);
        @(negedge clk);
        bus.exec = 1'b0;
        @(negedge clk);
        bus.A    = a;
        bus.B    = b;
        bus.oper = op;
        bus.exec = 1'b1;
        e        = model(a, b, op);
        e.due    = cyc + (((op == 3'd6) || (op == 3'd7 && b != 0)) ? W + 1 : 1);
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            check_output("drain_timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && bus.done) begin
                done_count++;
                if (sb_q.size() == 0) begin
                    check_output("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check_output("result", bus.result, e.result);
                    check_output("carry",  bus.carry,  e.carry);
                    check_output("zero",   bus.zero,   e.zero);
                    check_output("err",    bus.err,    e.err);
                    check_output("latency_cycle", cyc, e.due);
                end
            end
        end
    end

    initial begin : stimulus
        int d0;
        cyc        = 0;
        compared   = 0;
        mismatched = 0;
        done_count = 0;
        reset      = 1'b0;
        bus.A      = '1;
        bus.B      = '1;
        bus.oper   = '1;
        bus.exec   = 1'b1;
        #1;
        check_output("reset_result", bus.result, 16'h0000);
        check_output("reset_busy",   bus.busy,   1'b0);
        check_output("reset_done",   bus.done,   1'b0);
        check_output("reset_flags",  {bus.carry, bus.zero, bus.err}, 3'b000);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        d0    = done_count;
        repeat (20) @(negedge clk);
        check_output("no_start_from_reset_exec", done_count, d0);
        check_output("idle_result", bus.result, 16'h0000);
        check_output("idle_busy",   bus.busy,   1'b0);

        apply_stimulus(8'd200, 8'd100, 3'd0);
        apply_stimulus(8'd5,   8'd9,   3'd1);
        apply_stimulus(8'h3C,  8'h3C,  3'd4);
        apply_stimulus(8'hA5,  8'h0F,  3'd2);
        apply_stimulus(8'hA0,  8'h05,  3'd3);
        apply_stimulus(8'hFF,  8'd7,   3'd5);
        apply_stimulus(8'd200, 8'd7,   3'd7);
        apply_stimulus(8'd200, 8'd0,   3'd7);
        apply_stimulus(8'd0,   8'd0,   3'd7);
        drain();

        // MUL with operand changes and an exec re-pulse while busy
        d0 = done_count;
        apply_stimulus(8'd255, 8'd255, 3'd6);
        for (int k = 1; k <= W; k++) begin
            check_output("mul_busy", bus.busy, 1'b1);
            if (k == 3) begin
                bus.exec = 1'b0;
                bus.A    = 8'd3;
                bus.B    = 8'd0;
                bus.oper = 3'd0;
            end
            if (k == 5) bus.exec = 1'b1;
            @(negedge clk);
        end
        check_output("mul_busy_end", bus.busy, 1'b0);
        repeat (6) @(negedge clk);
        check_output("single_done_for_mul", done_count, d0 + 1);
        drain();

        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [2:0]   op;
            a  = W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            op = 3'($urandom_range(0, 7));
            apply_stimulus(a, b, op);
        end
        drain();

        // Reset in the middle of a multiply aborts without a done pulse
        apply_stimulus(8'd200, 8'd100, 3'd0);
        drain();
        @(negedge clk);
        bus.exec = 1'b0;
        @(negedge clk);
        bus.A    = 8'd255;
        bus.B    = 8'd255;
        bus.oper = 3'd6;
        bus.exec = 1'b1;
        repeat (4) @(negedge clk);
        check_output("abort_busy_before", bus.busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check_output("abort_result", bus.result, 16'h0000);
        check_output("abort_busy",   bus.busy,   1'b0);
        check_output("abort_done",   bus.done,   1'b0);
        check_output("abort_flags",  {bus.carry, bus.zero, bus.err}, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        d0    = done_count;
        repeat (20) @(negedge clk);
        check_output("no_done_after_abort", done_count, d0);

        apply_stimulus(8'd17, 8'd4, 3'd6);
        drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
